// File: rtl/trivium_pkg.sv
// Shared constants, state enum and load-mapping helpers for the Trivium keystream generator.
package trivium_pkg;

  localparam int STATE_W    = 288;
  localparam int KEY_W      = 80;
  localparam int IV_W       = 80;
  localparam int KEY_BYTES  = 10;
  localparam int IV_BYTES   = 10;
  localparam int LOAD_BYTES = KEY_BYTES + IV_BYTES;
  localparam int BCNT_W     = 5;

  // Tap positions use the 1-based numbering s1..s288; vector index is tap-1.
  localparam int TAP_66  = 66;
  localparam int TAP_69  = 69;
  localparam int TAP_91  = 91;
  localparam int TAP_92  = 92;
  localparam int TAP_93  = 93;
  localparam int TAP_162 = 162;
  localparam int TAP_171 = 171;
  localparam int TAP_175 = 175;
  localparam int TAP_176 = 176;
  localparam int TAP_177 = 177;
  localparam int TAP_243 = 243;
  localparam int TAP_264 = 264;
  localparam int TAP_286 = 286;
  localparam int TAP_287 = 287;
  localparam int TAP_288 = 288;

  localparam int IV_BASE = TAP_93;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_INIT = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  function automatic logic [8:0] byte_base(input logic [BCNT_W-1:0] n);
    logic [BCNT_W-1:0] k;
    if (n < BCNT_W'(KEY_BYTES)) return 9'({n, 3'b000});
    k = n - BCNT_W'(KEY_BYTES);
    return 9'(IV_BASE) + 9'({k, 3'b000});
  endfunction

  // Fresh state for key byte 0: constant ones in s286..s288, everything else cleared.
  function automatic logic [STATE_W-1:0] seed_state(input logic [7:0] b);
    logic [STATE_W-1:0] s;
    s              = '0;
    s[TAP_286-1]   = 1'b1;
    s[TAP_287-1]   = 1'b1;
    s[TAP_288-1]   = 1'b1;
    s[7:0]         = b;
    return s;
  endfunction

endpackage

// File: rtl/trivium_stream_gen_if.sv
// Load-byte and keystream handshake bundle; valid/ready pairs transfer on a clock edge where both are high.
// TRIVIUM_STREAM_XOR_EN adds the plaintext input and the completed-word counter.
interface trivium_stream_gen_if #(
  parameter int W = 8
) ();

  logic         load_valid;
  logic         load_ready;
  logic [7:0]   load_data;
  logic         busy;
  logic         ks_valid;
  logic         ks_ready;
  logic [W-1:0] ks_data;
`ifdef TRIVIUM_STREAM_XOR_EN
  logic [W-1:0] pt_data;
  logic [31:0]  ks_cnt;

  modport slave (
    input  load_valid, load_data, ks_ready, pt_data,
    output load_ready, busy, ks_valid, ks_data, ks_cnt
  );

  modport master (
    output load_valid, load_data, ks_ready, pt_data,
    input  load_ready, busy, ks_valid, ks_data, ks_cnt
  );
`else
  modport slave (
    input  load_valid, load_data, ks_ready,
    output load_ready, busy, ks_valid, ks_data
  );

  modport master (
    output load_valid, load_data, ks_ready,
    input  load_ready, busy, ks_valid, ks_data
  );
`endif

endinterface

// File: rtl/trivium_round_unroll.sv
// W Trivium rounds unrolled combinationally; z_o[0] is the output bit of the first round.
module trivium_round_unroll
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] state_o,
  output logic [W-1:0]       z_o
);

  always_comb begin : p_rounds
    logic [STATE_W-1:0] s;
    logic t1;
    logic t2;
    logic t3;
    s   = state_i;
    z_o = '0;
    t1  = 1'b0;
    t2  = 1'b0;
    t3  = 1'b0;
    for (int i = 0; i < W; i++) begin
      t1     = s[TAP_66-1]  ^ s[TAP_93-1];
      t2     = s[TAP_162-1] ^ s[TAP_177-1];
      t3     = s[TAP_243-1] ^ s[TAP_288-1];
      z_o[i] = t1 ^ t2 ^ t3;
      t1     = t1 ^ (s[TAP_91-1]  & s[TAP_92-1])  ^ s[TAP_171-1];
      t2     = t2 ^ (s[TAP_175-1] & s[TAP_176-1]) ^ s[TAP_264-1];
      t3     = t3 ^ (s[TAP_286-1] & s[TAP_287-1]) ^ s[TAP_69-1];
      // Three registers shift by one: s1..s93 <- t3, s94..s177 <- t1, s178..s288 <- t2.
      s      = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    state_o = s;
  end

endmodule

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator: byte-serial key/IV load, internal warm-up, W keystream bits per handshake.
// Build option TRIVIUM_STREAM_XOR_EN: ks_data = keystream ^ pt_data and a 32-bit completed-word counter.
module trivium_stream_gen
  import trivium_pkg::*;
#(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  trivium_stream_gen_if.slave   bus,
  output state_e                dbg_state,
  output logic [BCNT_W-1:0]     dbg_byte_cnt
);

  localparam int INIT_CYCLES = INIT_ROUNDS / W;
  localparam int RND_W       = $clog2(INIT_CYCLES + 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64) ||
      (INIT_ROUNDS % W) != 0 || INIT_ROUNDS < W ||
      KEY_W != 8 * KEY_BYTES || IV_W != 8 * IV_BYTES) begin : g_bad_param
    $error("trivium_stream_gen: W must be a power of two in 1..64 dividing INIT_ROUNDS");
  end

  state_e             state_q, state_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [STATE_W-1:0] s_q, s_d, s_adv;
  logic [W-1:0]       z;
  logic               load_ready;
  logic               load_acc;
  logic               last_byte;
  logic               run;

  trivium_round_unroll #(.W(W)) u_round (
    .state_i (s_q),
    .state_o (s_adv),
    .z_o     (z)
  );

  assign run        = (state_q == ST_RUN);
  assign load_ready = (state_q != ST_INIT);
  assign load_acc   = bus.load_valid && load_ready;
  assign last_byte  = (bcnt_q == BCNT_W'(LOAD_BYTES - 1));

  assign bus.load_ready = load_ready;
  assign bus.busy       = (state_q == ST_INIT);
  assign bus.ks_valid   = run;
`ifdef TRIVIUM_STREAM_XOR_EN
  assign bus.ks_data    = run ? (z ^ bus.pt_data) : '0;
`else
  assign bus.ks_data    = run ? z : '0;
`endif

  assign dbg_state    = state_q;
  assign dbg_byte_cnt = bcnt_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    if (clear) begin
      state_d = ST_IDLE;
      bcnt_d  = '0;
      rnd_d   = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_acc) begin
            s_d     = seed_state(bus.load_data);
            bcnt_d  = BCNT_W'(1);
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            s_d[byte_base(bcnt_q) +: 8] = bus.load_data;
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (last_byte) begin
              state_d = ST_INIT;
              rnd_d   = '0;
            end
          end
        end
        ST_INIT: begin
          s_d   = s_adv;
          rnd_d = rnd_q + RND_W'(1);
          if (rnd_q == RND_W'(INIT_CYCLES - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A load byte aborts the stream even when the current word is also taken.
          if (load_acc) begin
            s_d     = seed_state(bus.load_data);
            bcnt_d  = BCNT_W'(1);
            state_d = ST_LOAD;
          end else if (bus.ks_ready) begin
            s_d = s_adv;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      rnd_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
    end
  end

`ifdef TRIVIUM_STREAM_XOR_EN
  logic [31:0] cnt_q, cnt_d;
  logic        ks_fire;

  assign ks_fire    = run && bus.ks_ready;
  assign bus.ks_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (state_q == ST_LOAD && load_acc && last_byte) begin
      cnt_d = '0;
    end else if (ks_fire) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_trivium_stream_gen.sv
// Bench for trivium_stream_gen: randomized load gaps and backpressure, scoreboard fed by a bit-serial Trivium model.
module tb_trivium_stream_gen;
  import trivium_pkg::*;

  localparam int W           = 8;
  localparam int INIT_ROUNDS = 1152;
  localparam int N_INIT      = INIT_ROUNDS / W;
  localparam logic [63:0] PT_PAT = {8{8'hA5}};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  state_e            dbg_state;
  logic [BCNT_W-1:0] dbg_byte_cnt;

  trivium_stream_gen_if #(.W(W)) bus ();

  trivium_stream_gen #(.W(W), .INIT_ROUNDS(INIT_ROUNDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_byte_cnt (dbg_byte_cnt)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           words_since_init = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pt_mask;
  logic [7:0]   ld_b[20];
  bit           m_s[1:288];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one Trivium round on the 1-based state, returning its output bit.
  function automatic bit model_bit();
    bit t1, t2, t3, z;
    t1 = m_s[66] ^ m_s[93];
    t2 = m_s[162] ^ m_s[177];
    t3 = m_s[243] ^ m_s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m_s[91] & m_s[92]) ^ m_s[171];
    t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
    t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
    for (int i = 288; i > 178; i--) m_s[i] = m_s[i-1];
    m_s[178] = t2;
    for (int i = 177; i > 94; i--) m_s[i] = m_s[i-1];
    m_s[94] = t1;
    for (int i = 93; i > 1; i--) m_s[i] = m_s[i-1];
    m_s[1] = t3;
    return z;
  endfunction

  function automatic void model_key();
    for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
    for (int n = 0; n < 20; n++)
      for (int j = 0; j < 8; j++)
        if (n < 10) m_s[8*n + j + 1] = ld_b[n][j];
        else        m_s[93 + 8*(n-10) + j + 1] = ld_b[n][j];
    m_s[286] = 1'b1;
    m_s[287] = 1'b1;
    m_s[288] = 1'b1;
    for (int r = 0; r < INIT_ROUNDS; r++) void'(model_bit());
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = model_bit();
    return w;
  endfunction

  // Monitor: every valid cycle must show the head of the queue; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n && bus.ks_valid) begin
      if (exp_q.size() > 0) begin
        check("ks_data", 64'(bus.ks_data), 64'(exp_q[0]));
        if (bus.ks_ready) void'(exp_q.pop_front());
      end else if (bus.ks_ready) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.ks_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int mode);
    for (int n = 0; n < 20; n++) begin
      case (mode)
        0:       ld_b[n] = 8'h00;
        1:       ld_b[n] = (n == 0) ? 8'h80 : 8'h00;
        default: ld_b[n] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic load_bytes(input int first, input int last);
    for (int n = first; n <= last; n++) begin
      repeat ($urandom_range(0, 1)) tick();
      bus.load_valid = 1'b1;
      bus.load_data  = ld_b[n];
      tick();
      bus.load_valid = 1'b0;
    end
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("busy_cycles", 64'(cnt), 64'(N_INIT));
    check("valid_after_init", 64'(bus.ks_valid), 64'd1);
    words_since_init = 0;
`ifdef TRIVIUM_STREAM_XOR_EN
    check("ks_cnt_after_init", 64'(bus.ks_cnt), 64'd0);
`endif
  endtask

  task automatic session(input int n, input bit rnd);
    int guard;
    for (int i = 0; i < n; i++) exp_q.push_back(model_word() ^ pt_mask);
    guard = 0;
    while (exp_q.size() > 0 && guard < 40 * n + 100) begin
      bus.ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    bus.ks_ready = 1'b0;
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    words_since_init += n;
`ifdef TRIVIUM_STREAM_XOR_EN
    check("ks_cnt", 64'(bus.ks_cnt), 64'(words_since_init));
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    check({tag, "_byte_cnt"}, 64'(dbg_byte_cnt), 64'd0);
    check({tag, "_ks_valid"}, 64'(bus.ks_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_load_ready"}, 64'(bus.load_ready), 64'd1);
    check({tag, "_ks_data"}, 64'(bus.ks_data), 64'd0);
`ifdef TRIVIUM_STREAM_XOR_EN
    check({tag, "_ks_cnt"}, 64'(bus.ks_cnt), 64'd0);
`endif
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.ks_ready   = 1'b0;
`ifdef TRIVIUM_STREAM_XOR_EN
    pt_mask        = PT_PAT[W-1:0];
    bus.pt_data    = PT_PAT[W-1:0];
`else
    pt_mask        = '0;
`endif
    #2;
    check_idle("in_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("after_reset");

    // All-zero key and IV, consumer always ready.
    set_key(0);
    load_bytes(0, 19);
    model_key();
    wait_init();
    session(512 / W, 1'b0);
    session(100 - 512 / W, 1'b1);

    // Key byte 0x80, rest zero; 1024 bits under random backpressure (rekeys from RUN).
    set_key(1);
    load_bytes(0, 19);
    model_key();
    wait_init();
    session(1024 / W, 1'b1);

    // Rekey after 10 words; the first new byte coincides with a word handshake.
    set_key(2);
    load_bytes(0, 19);
    model_key();
    wait_init();
    session(10, 1'b1);
    exp_q.push_back(model_word() ^ pt_mask);
    set_key(2);
    bus.ks_ready   = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = ld_b[0];
    tick();
    bus.ks_ready   = 1'b0;
    bus.load_valid = 1'b0;
    check("rekey_one_word", 64'(exp_q.size()), 64'd0);
    check("rekey_state", 64'(dbg_state), 64'(ST_LOAD));
    check("rekey_byte_cnt", 64'(dbg_byte_cnt), 64'd1);
    load_bytes(1, 19);
    model_key();
    wait_init();
    session(32, 1'b1);

    // rst_n / clear at load byte 7 and at INIT cycle 50, each followed by a full reload.
    for (int m = 0; m < 4; m++) begin
      set_key(2);
      if (m >= 2) begin
        load_bytes(0, 19);
        repeat (50) tick();
        check("mid_init_busy", 64'(bus.busy), 64'd1);
      end else begin
        load_bytes(0, 6);
        check("byte7_cnt", 64'(dbg_byte_cnt), 64'd7);
      end
      if (m % 2 == 1) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        clear          = 1'b1;
        tick();
        clear          = 1'b0;
        bus.load_valid = 1'b0;
        check_idle("clear");
      end else begin
        rst_n = 1'b0;
        #2;
        check_idle("rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("rst_release");
      end
      set_key(2);
      load_bytes(0, 19);
      model_key();
      wait_init();
      session(16, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trivium_stream_gen.md
Name: trivium_stream_gen

Overview:
- Parametrised Trivium keystream generator.
- Produces W keystream bits per clock, where W is 1..64.
- Key and IV are loaded over a byte-wide serial interface instead of 80-bit parallel ports.
- Runs the full initialisation phase internally, then streams keystream words over a valid/ready handshake.
- Sits behind the chip top wrapper; the byte load port maps onto the 8-bit dedicated inputs.

Parameters:
- W, 8, keystream bits per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (must divide INIT_ROUNDS; elaboration error otherwise).
- INIT_ROUNDS, 1152, warm-up rounds discarded before output; must be a multiple of W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous soft reset to IDLE; state register and byte counter zeroed.
- load_valid  in  1  load byte present.
- load_ready  out  1  high in IDLE, LOAD and RUN; low in INIT.
- load_data  in  8  key/IV byte.
- busy  out  1  high in INIT.
- ks_valid  out  1  keystream word available; high only in RUN.
- ks_ready  in  1  consumer accepts word.
- ks_data  out  W  keystream word; ks_data[0] is the earliest bit.

Behaviour:
- Reset (rst_n low or clear high):
  - state = IDLE, byte counter = 0, all 288 state bits = 0.
  - load_ready = 1, busy = 0, ks_valid = 0, ks_data = 0.
- States: IDLE, LOAD, INIT, RUN.
- Load byte mapping:
  - A byte is accepted when load_valid && load_ready.
  - Byte n (0..19), bit j: n<10 -> s[8n+j+1] = K(8n+j+1); n>=10 -> s[93+8(n-10)+j+1] = IV(8(n-10)+j+1).
  - Everything else is 0, except s286, s287, s288 = 1, which are set on the first accepted byte.
- IDLE -> LOAD on the first accepted byte.
- LOAD -> INIT on the 20th accepted byte. The round counter is cleared to 0 on that edge.
- INIT:
  - Each cycle applies W Trivium rounds, unrolled, with output bits discarded.
  - The state leaves INIT after INIT_ROUNDS/W cycles (144 for the defaults), then goes to RUN.
  - load_valid is ignored in INIT.
- RUN:
  - ks_valid = 1; ks_data holds the next W output bits z(i), computed combinationally from the current state.
  - On ks_valid && ks_ready the state advances W rounds.
  - With ks_ready low, state and ks_data hold indefinitely.
- Rekey in RUN:
  - An accepted load byte in RUN aborts the stream and moves to LOAD with the counter at 1. That byte becomes key byte 0, and the state is reinitialised exactly as from IDLE.
  - If ks_ready and load_valid are both high in the same cycle, the output word counts as consumed and the load byte is accepted; the load transition wins.
- Round-counter width is clog2(INIT_ROUNDS/W + 1). No wrap-around in RUN: the stream is unbounded.
- clear has priority over every other input in the same cycle.
- rst_n deasserted mid-INIT returns to IDLE; no partial key is retained.

Optional Feature:
- Macro: TRIVIUM_STREAM_XOR_EN.
- Defined:
  - Adds input pt_data[W-1:0].
  - ks_data becomes keystream XOR pt_data (stream encrypt/decrypt). pt_data is sampled under the same ks_valid && ks_ready handshake.
  - Adds output ks_cnt[31:0], which counts completed output words. It is zeroed on reset, clear and entry to INIT, and wraps at 2^32.
- Undefined: no pt_data or ks_cnt ports; ks_data is the raw keystream.

Decomposition:
- Package trivium_pkg:
  - STATE_W=288, KEY_W=80, IV_W=80, KEY_BYTES=10, IV_BYTES=10.
  - Tap index constants 66, 69, 91, 92, 93, 162, 171, 175, 176, 177, 243, 264, 286, 287, 288.
  - State enum typedef for IDLE, LOAD, INIT, RUN.
- Sub-module trivium_round_unroll: combinational, parameter W. Takes the 288-bit state in and returns the next 288-bit state and W output bits. It is instanced once and shared by INIT and RUN.

Test Plan:
- Reference check, W=1 and W=8: key=0, IV=0, load 20 zero bytes, ks_ready=1.
  - busy is high for exactly 1152 (W=1) or 144 (W=8) cycles.
  - The first 512 output bits match the bit-serial golden model and the published all-zero Trivium vector.
- Parameter sweep: key=0x80 followed by 9 zero bytes, IV=0, run at W=1, 16 and 64.
  - Concatenated streams are identical across W for 1024 bits.
- Backpressure: toggle ks_ready with a random 50% pattern.
  - ks_data stays stable while ks_ready is low.
  - No bits are lost or duplicated against the golden stream.
- Rekey: in RUN, after 10 words, load a new 20-byte key/IV.
  - Output equals a fresh-reset run with the same key/IV.
  - A load byte and a ks_ready handshake in the same cycle consume exactly one word.
- Reset mid-operation: drop rst_n, then separately pulse clear, at INIT cycle 50 and at load byte 7.
  - state = IDLE, ks_valid = 0, counter = 0.
  - A following full load gives the reference stream.
- With TRIVIUM_STREAM_XOR_EN: pt_data = 0xA5 per byte.
  - ks_data = golden ^ 0xA5.
  - ks_cnt = 100 after 100 handshakes.
  - ks_cnt resets to 0 on entry to INIT.
